async_fifo_param: RTL and testbench

Parametrised dual-clock FIFO carrying data words from the `Wr_clk` domain to the `Rd_clk` domain. Depth is any power of two and data width is configurable. Each domain sees its own fill level, programmable almost-full / almost-empty flags, and sticky overflow/underflow error flags. It is the standard clock-domain-crossing buffer for new datapaths, with an optional first-word-fall-through read mode.

---
 rtl/async_fifo_param.sv | 162 ++++++++++++++++
 tb/tb_async_fifo_param.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_param.sv
// Dual-clock FIFO: Gray-coded pointers cross through 2-flop synchronizers, each side derives its own level and flags.
// Optional first-word-fall-through read mode is enabled by defining ASYNC_FIFO_FWFT_EN.
`timescale 1ns/1ps
module async_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 4
) (
  input  logic              Wr_clk,
  input  logic              reset,
  input  logic              Rd_clk,
  input  logic              Wr_en,
  input  logic [WIDTH-1:0]  Data_in,
  output logic              Wr_full,
  output logic              Wr_almost_full,
  output logic [ADDR_W:0]   Wr_level,
  output logic              Wr_overflow,
  input  logic              Rd_en,
  output logic [WIDTH-1:0]  Data_out,
  output logic              Rd_valid,
  output logic              Rd_empty,
  output logic              Rd_almost_empty,
  output logic [ADDR_W:0]   Rd_level,
  output logic              Rd_underflow
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W:0] AF_L    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_L    = (ADDR_W+1)'(AE_THRESH);

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    for (int i = 0; i <= ADDR_W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  logic [ADDR_W:0] wptrBin_q, wptrBin_d, wptrGray_q;
  logic [ADDR_W:0] rptrSync1_q, rptrSync2_q, rptrSyncBin;
  logic            wrOverflow_q, wrOverflow_d, wrAccept;

  logic [ADDR_W:0] rptrBin_q, rptrBin_d, rptrGray_q;
  logic [ADDR_W:0] wptrSync1_q, wptrSync2_q, wptrSyncBin, memLevel;
  logic [ADDR_W+1:0] rdLevelWide;
  logic            rstSync1_q, rstSync2_q, rdRst;
  logic            rdUnderflow_q, rdUnderflow_d, rdValid_q, rdValid_d, memEmpty;
  logic [WIDTH-1:0] dataOut_q, dataOut_d;

  assign rptrSyncBin    = gray2bin(rptrSync2_q);
  assign Wr_level       = wptrBin_q - rptrSyncBin;
  assign Wr_full        = (Wr_level == DEPTH_L);
  assign Wr_almost_full = (Wr_level >= AF_L);
  assign Wr_overflow    = wrOverflow_q;
  assign wrAccept       = Wr_en && !Wr_full && !reset;

  always_comb begin
    wptrBin_d    = wptrBin_q;
    wrOverflow_d = wrOverflow_q;
    if (wrAccept) wptrBin_d = wptrBin_q + ONE;
    if (Wr_en && Wr_full) wrOverflow_d = 1'b1;
  end

  always_ff @(posedge Wr_clk) begin
    if (reset) begin
      wptrBin_q    <= '0;
      wptrGray_q   <= '0;
      rptrSync1_q  <= '0;
      rptrSync2_q  <= '0;
      wrOverflow_q <= 1'b0;
    end else begin
      wptrBin_q    <= wptrBin_d;
      wptrGray_q   <= bin2gray(wptrBin_d);
      rptrSync1_q  <= rptrGray_q;
      rptrSync2_q  <= rptrSync1_q;
      wrOverflow_q <= wrOverflow_d;
    end
  end

  always_ff @(posedge Wr_clk) begin
    if (wrAccept) mem[wptrBin_q[ADDR_W-1:0]] <= Data_in;
  end

  // The read domain gets its own synchronized copy of the write-domain reset.
  always_ff @(posedge Rd_clk) begin
    rstSync1_q <= reset;
    rstSync2_q <= rstSync1_q;
  end
  assign rdRst = rstSync2_q;

  assign wptrSyncBin = gray2bin(wptrSync2_q);
  assign memLevel    = wptrSyncBin - rptrBin_q;
  assign memEmpty    = (memLevel == '0);

  always_comb begin
    rptrBin_d     = rptrBin_q;
    rdUnderflow_d = rdUnderflow_q;
    rdValid_d     = 1'b0;
    dataOut_d     = dataOut_q;
    rdLevelWide   = {1'b0, memLevel};
`ifdef ASYNC_FIFO_FWFT_EN
    rdValid_d = rdValid_q;
    if (Rd_en) rdValid_d = 1'b0;
    if (!memEmpty && (!rdValid_q || Rd_en)) begin
      dataOut_d = mem[rptrBin_q[ADDR_W-1:0]];
      rptrBin_d = rptrBin_q + ONE;
      rdValid_d = 1'b1;
    end
    if (Rd_en && !rdValid_q) rdUnderflow_d = 1'b1;
    rdLevelWide = {1'b0, memLevel} + {{(ADDR_W+1){1'b0}}, rdValid_q};
`else
    if (Rd_en && !memEmpty) begin
      dataOut_d = mem[rptrBin_q[ADDR_W-1:0]];
      rptrBin_d = rptrBin_q + ONE;
      rdValid_d = 1'b1;
    end
    if (Rd_en && memEmpty) rdUnderflow_d = 1'b1;
`endif
  end

  always_ff @(posedge Rd_clk) begin
    if (rdRst) begin
      rptrBin_q     <= '0;
      rptrGray_q    <= '0;
      wptrSync1_q   <= '0;
      wptrSync2_q   <= '0;
      rdUnderflow_q <= 1'b0;
      rdValid_q     <= 1'b0;
      dataOut_q     <= '0;
    end else begin
      rptrBin_q     <= rptrBin_d;
      rptrGray_q    <= bin2gray(rptrBin_d);
      wptrSync1_q   <= wptrGray_q;
      wptrSync2_q   <= wptrSync1_q;
      rdUnderflow_q <= rdUnderflow_d;
      rdValid_q     <= rdValid_d;
      dataOut_q     <= dataOut_d;
    end
  end

  // The output register can hold one word beyond the memory, so clamp the reported level.
  assign Rd_level        = (rdLevelWide > DEPTH_W) ? DEPTH_L : rdLevelWide[ADDR_W:0];
  assign Rd_almost_empty = (Rd_level <= AE_L);
  assign Rd_valid        = rdValid_q;
  assign Rd_underflow    = rdUnderflow_q;
  assign Data_out        = dataOut_q;
`ifdef ASYNC_FIFO_FWFT_EN
  assign Rd_empty = !rdValid_q;
`else
  assign Rd_empty = memEmpty;
`endif

endmodule

// File: tb/tb_async_fifo_param.sv
// Scoreboard bench for async_fifo_param: a queue model of accepted writes is popped by a read-side monitor.
`timescale 1ns/1ps
module tb_async_fifo_param;

  logic        Wr_clk = 1'b0;
  logic        Rd_clk = 1'b0;
  logic        reset  = 1'b1;
  logic        Wr_en  = 1'b0;
  logic        Rd_en  = 1'b0;
  logic [7:0]  Data_in = 8'h00;
  logic        Wr_full, Wr_almost_full, Wr_overflow;
  logic [4:0]  Wr_level, Rd_level;
  logic [7:0]  Data_out;
  logic        Rd_valid, Rd_empty, Rd_almost_empty, Rd_underflow;

  realtime wrHalf = 5.0;
  realtime rdHalf = 13.5;

  int testsRun = 0;
  int failures = 0;
  int rxCount  = 0;
  logic [7:0] sb [$];
  logic [7:0] expWord;
  bit take;

  async_fifo_param #(.WIDTH(8), .ADDR_W(4), .AF_THRESH(12), .AE_THRESH(4)) dut (
    .Wr_clk(Wr_clk), .reset(reset), .Rd_clk(Rd_clk),
    .Wr_en(Wr_en), .Data_in(Data_in), .Wr_full(Wr_full),
    .Wr_almost_full(Wr_almost_full), .Wr_level(Wr_level), .Wr_overflow(Wr_overflow),
    .Rd_en(Rd_en), .Data_out(Data_out), .Rd_valid(Rd_valid), .Rd_empty(Rd_empty),
    .Rd_almost_empty(Rd_almost_empty), .Rd_level(Rd_level), .Rd_underflow(Rd_underflow)
  );

  always #(wrHalf) Wr_clk = ~Wr_clk;
  always #(rdHalf) Rd_clk = ~Rd_clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Every word leaving the FIFO must be the oldest word the model still holds.
  always @(negedge Rd_clk) begin
`ifdef ASYNC_FIFO_FWFT_EN
    take = Rd_valid && Rd_en;
`else
    take = Rd_valid;
`endif
    if (take) begin
      if (sb.size() == 0) begin
        testsRun++;
        failures++;
        $display("[TB] FAIL unexpected_word: got 0x%0h with model queue empty", Data_out);
      end else begin
        expWord = sb.pop_front();
        checkOutput("read_data", int'(Data_out), int'(expWord));
        rxCount++;
      end
    end
  end

  task automatic applyStimulus(input bit en, input logic [7:0] d);
    Wr_en   = en;
    Data_in = d;
    @(posedge Wr_clk);
    #0.1;
    Wr_en = 1'b0;
  endtask

  task automatic applyRead(input bit en);
    Rd_en = en;
    @(posedge Rd_clk);
    #0.1;
    Rd_en = 1'b0;
  endtask

  task automatic doReset();
    @(posedge Wr_clk);
    #0.1;
    reset = 1'b1;
    Wr_en = 1'b0;
    Rd_en = 1'b0;
    repeat (4) @(posedge Rd_clk);
    repeat (4) @(posedge Wr_clk);
    #0.1;
    reset = 1'b0;
    repeat (4) @(posedge Rd_clk);
    #0.1;
    sb.delete();
  endtask

  task automatic runRandom(input realtime wh, input realtime rh, input int n);
    int startRx;
    wrHalf = wh;
    rdHalf = rh;
    doReset();
    startRx = rxCount;
    fork
      begin : writer
        int sent;
        int budget;
        logic [7:0] d;
        sent = 0;
        budget = 0;
        while (sent < n && budget < 5000) begin
          budget++;
          if (!Wr_full && $urandom_range(0, 3) != 0) begin
            d = 8'($urandom);
            sb.push_back(d);
            applyStimulus(1'b1, d);
            sent++;
          end else begin
            applyStimulus(1'b0, 8'h00);
          end
          checkOutput("rand_wr_level_range", int'(Wr_level <= 5'd16), 1);
          checkOutput("rand_overflow", int'(Wr_overflow), 0);
        end
        checkOutput("rand_writer_done", sent, n);
      end
      begin : reader
        int budget;
        budget = 0;
        while ((rxCount - startRx) < n && budget < 10000) begin
          budget++;
          applyRead(!Rd_empty && $urandom_range(0, 2) != 0);
          checkOutput("rand_underflow", int'(Rd_underflow), 0);
          checkOutput("rand_rd_level_range", int'(Rd_level <= 5'd16), 1);
        end
        checkOutput("rand_reader_done", rxCount - startRx, n);
      end
    join
    checkOutput("rand_queue_drained", sb.size(), 0);
  endtask

  initial begin
    int startRx;
    int w;
    doReset();

    checkOutput("reset_wr_full", int'(Wr_full), 0);
    checkOutput("reset_wr_almost_full", int'(Wr_almost_full), 0);
    checkOutput("reset_wr_level", int'(Wr_level), 0);
    checkOutput("reset_wr_overflow", int'(Wr_overflow), 0);
    checkOutput("reset_rd_empty", int'(Rd_empty), 1);
    checkOutput("reset_rd_almost_empty", int'(Rd_almost_empty), 1);
    checkOutput("reset_rd_level", int'(Rd_level), 0);
    checkOutput("reset_rd_valid", int'(Rd_valid), 0);
    checkOutput("reset_data_out", int'(Data_out), 0);
    checkOutput("reset_rd_underflow", int'(Rd_underflow), 0);

`ifndef ASYNC_FIFO_FWFT_EN
    for (int k = 1; k <= 16; k++) begin
      sb.push_back(8'(k));
      applyStimulus(1'b1, 8'(k));
      checkOutput("fill_wr_level", int'(Wr_level), k);
      checkOutput("fill_almost_full", int'(Wr_almost_full), int'(k >= 12));
      checkOutput("fill_full", int'(Wr_full), int'(k == 16));
    end

    applyStimulus(1'b1, 8'hAA);
    checkOutput("ovf_flag", int'(Wr_overflow), 1);
    checkOutput("ovf_level", int'(Wr_level), 16);
    checkOutput("ovf_full", int'(Wr_full), 1);
    repeat (5) @(posedge Wr_clk);
    #0.1;
    checkOutput("ovf_sticky", int'(Wr_overflow), 1);
    checkOutput("ovf_level_hold", int'(Wr_level), 16);

    repeat (6) @(posedge Rd_clk);
    #0.1;
    checkOutput("drain_start_level", int'(Rd_level), 16);
    checkOutput("drain_start_empty", int'(Rd_empty), 0);
    startRx = rxCount;
    for (int i = 1; i <= 17; i++) begin
      applyRead(1'b1);
      if (i <= 16) begin
        checkOutput("drain_rd_level", int'(Rd_level), 16 - i);
        checkOutput("drain_almost_empty", int'(Rd_almost_empty), int'((16 - i) <= 4));
        checkOutput("drain_rd_empty", int'(Rd_empty), int'(i == 16));
        checkOutput("drain_no_underflow", int'(Rd_underflow), 0);
      end else begin
        checkOutput("drain_underflow", int'(Rd_underflow), 1);
      end
    end
    @(negedge Rd_clk);
    #0.1;
    checkOutput("drain_valid_pulses", rxCount - startRx, 16);
    checkOutput("drain_queue_empty", sb.size(), 0);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h20 + i));
    doReset();
    checkOutput("midrst_rd_empty", int'(Rd_empty), 1);
    checkOutput("midrst_wr_level", int'(Wr_level), 0);
    checkOutput("midrst_rd_level", int'(Rd_level), 0);
    checkOutput("midrst_overflow", int'(Wr_overflow), 0);
    checkOutput("midrst_underflow", int'(Rd_underflow), 0);
    sb.push_back(8'h55);
    applyStimulus(1'b1, 8'h55);
    startRx = rxCount;
    w = 0;
    while (Rd_empty && w < 20) begin
      @(posedge Rd_clk);
      #0.1;
      w++;
    end
    checkOutput("midrst_word_visible", int'(Rd_empty), 0);
    applyRead(1'b1);
    @(negedge Rd_clk);
    #0.1;
    checkOutput("midrst_first_read", rxCount - startRx, 1);
`else
    sb.push_back(8'h3C);
    applyStimulus(1'b1, 8'h3C);
    w = 0;
    while (!Rd_valid && w < 20) begin
      @(posedge Rd_clk);
      #0.1;
      w++;
    end
    checkOutput("fwft_valid", int'(Rd_valid), 1);
    checkOutput("fwft_data", int'(Data_out), 8'h3C);
    checkOutput("fwft_level", int'(Rd_level), 1);
    checkOutput("fwft_not_empty", int'(Rd_empty), 0);
    applyRead(1'b1);
    checkOutput("fwft_valid_after_ack", int'(Rd_valid), 0);
    checkOutput("fwft_empty_after_ack", int'(Rd_empty), 1);
    checkOutput("fwft_no_underflow", int'(Rd_underflow), 0);
`endif

    runRandom(5.0, 15.0, 350);
    runRandom(5.0, 5.1, 350);
    runRandom(15.0, 5.0, 350);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
